// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - state encodings and constants for mem_port_arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  localparam int          ARB_TIMEOUT_CYC = 256;
  localparam logic [31:0] ARB_ZERO_DATA   = 32'h0000_0000;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// rtl/mem_port_arbiter_watchdog.sv - bus ack watchdog (arb_watchdog), used only with ARB_TIMEOUT_EN
module arb_watchdog #(
  parameter int TIMEOUT_CYC = 256,
  parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  // Fires in the last waiting cycle so the abort edge is the one that reaches TIMEOUT_CYC.
  assign expire = enable && (cnt == LAST_WAIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM single-port bus arbiter; optional watchdog via ARB_TIMEOUT_EN
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC,
  parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic        flush,
  output logic        stall_fetch,
  output logic        stall_mem,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  arb_state_t  state, state_nxt;
  logic        drop_fetch, drop_nxt;
  logic        bus_req_nxt, bus_we_nxt;
  logic [31:0] bus_addr_nxt, bus_wdata_nxt;
  logic [3:0]  bus_wmask_nxt;
  logic [31:0] if_rdata_nxt, mem_rdata_nxt;
  logic        if_ready_nxt, mem_ready_nxt, bus_err_nxt;
  logic        wd_expire;
  logic        txn_done, timed_out;
  logic [31:0] done_data;

`ifdef ARB_TIMEOUT_EN
  arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ARB_IDLE),
    .enable ((state != ARB_IDLE) && !bus_ack),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  assign stall_fetch = if_req  & ~if_ready;
  assign stall_mem   = mem_req & ~mem_ready;

  assign txn_done  = bus_ack | wd_expire;
  assign timed_out = wd_expire & ~bus_ack;
  assign done_data = bus_ack ? bus_rdata : ARB_ZERO_DATA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      drop_fetch <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wmask  <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop_fetch <= drop_nxt;
      bus_req    <= bus_req_nxt;
      bus_we     <= bus_we_nxt;
      bus_addr   <= bus_addr_nxt;
      bus_wdata  <= bus_wdata_nxt;
      bus_wmask  <= bus_wmask_nxt;
      if_rdata   <= if_rdata_nxt;
      mem_rdata  <= mem_rdata_nxt;
      if_ready   <= if_ready_nxt;
      mem_ready  <= mem_ready_nxt;
      bus_err    <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drop_nxt      = drop_fetch;
    bus_req_nxt   = bus_req;
    bus_we_nxt    = bus_we;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    bus_wmask_nxt = bus_wmask;
    if_rdata_nxt  = if_rdata;
    mem_rdata_nxt = mem_rdata;
    if_ready_nxt  = 1'b0;
    mem_ready_nxt = 1'b0;
    bus_err_nxt   = 1'b0;

    case (state)
      ARB_IDLE: begin
        // A request whose ready is high this cycle is the one being consumed; never relaunch it.
        if (mem_req && !mem_ready) begin
          state_nxt     = ARB_DATA;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = mem_we;
          bus_addr_nxt  = mem_addr;
          bus_wdata_nxt = mem_wdata;
          bus_wmask_nxt = mem_wmask;
        end else if (if_req && !if_ready) begin
          state_nxt     = ARB_FETCH;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = 1'b0;
          bus_addr_nxt  = if_addr;
          bus_wdata_nxt = ARB_ZERO_DATA;
          bus_wmask_nxt = 4'b0000;
          drop_nxt      = flush;
        end
      end

      ARB_FETCH: begin
        if (txn_done) begin
          state_nxt   = ARB_IDLE;
          bus_req_nxt = 1'b0;
          drop_nxt    = 1'b0;
          bus_err_nxt = timed_out;
          if (!drop_fetch && !flush && if_req) begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = done_data;
          end
        end else if (flush) begin
          drop_nxt = 1'b1;
        end
      end

      ARB_DATA: begin
        // Flush is ignored here: the load/store is older than the branch that flushed.
        if (txn_done) begin
          state_nxt   = ARB_IDLE;
          bus_req_nxt = 1'b0;
          bus_err_nxt = timed_out;
          if (mem_req) begin
            mem_ready_nxt = 1'b1;
            mem_rdata_nxt = bus_we ? ARB_ZERO_DATA : done_data;
          end
        end
      end

      default: begin
        state_nxt   = ARB_IDLE;
        bus_req_nxt = 1'b0;
      end
    endcase
  end

endmodule
